hamming_decoder: RTL and testbench

Single-error-correcting decoder for the team's 11-bit Hamming codeword: 7 data bits with parity at positions 1, 2, 4 and 8. It sits at the receive end of the link fed by the Hamming encoder. Each accepted codeword is checked and corrected, the 7-bit payload is recovered, and saturating error counters are kept for link monitoring. The block is a two-stage pipeline with valid/ready handshakes on both sides.

---
 rtl/hamming_decoder.sv | 110 +++++++++++
 tb/tb_hamming_decoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decoder.sv
// Two-stage SEC decoder for the 11-bit Hamming link word (7 data bits, parity at 1/2/4/8).
// Stage 1 holds the codeword and its syndrome; stage 2 holds the corrected payload and flags.
module hamming_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:1]      in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:1]       out_data,
    output logic [3:0]       out_syndrome,
    output logic             out_err_corr,
    output logic             out_err_uncorr,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    logic        s1_valid;
    logic [11:1] s1_code;
    logic [3:0]  s1_syn;
    logic [3:0]  syn_in;
    logic        advance;
    logic        accept;
    logic        drain;
    logic [11:1] fixed;
    logic [7:1]  data_nx;
    logic        corr_nx;
    logic        uncorr_nx;

    always_comb begin
        syn_in[0] = in_code[1] ^ in_code[3] ^ in_code[5] ^ in_code[7] ^ in_code[9] ^ in_code[11];
        syn_in[1] = in_code[2] ^ in_code[3] ^ in_code[6] ^ in_code[7] ^ in_code[10] ^ in_code[11];
        syn_in[2] = in_code[4] ^ in_code[5] ^ in_code[6] ^ in_code[7];
        syn_in[3] = in_code[8] ^ in_code[9] ^ in_code[10] ^ in_code[11];
    end

    // Stage 1 may move on when stage 2 is empty or being drained this cycle.
    assign drain    = out_valid & out_ready;
    assign advance  = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | advance;
    assign accept   = in_valid & in_ready;

    always_comb begin
        fixed     = s1_code;
        corr_nx   = 1'b0;
        uncorr_nx = 1'b0;
        if (s1_syn >= 4'd12) begin
            uncorr_nx = 1'b1;
        end else if (s1_syn != 4'd0) begin
            corr_nx = 1'b1;
            for (int i = 1; i <= 11; i++) begin
                if (s1_syn == 4'(i)) fixed[i] = ~s1_code[i];
            end
        end
        data_nx = {fixed[11], fixed[10], fixed[9], fixed[7], fixed[6], fixed[5], fixed[3]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_code  <= in_code;
            s1_syn   <= syn_in;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Output fields only change on a load, so a stalled word holds stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_syndrome   <= '0;
            out_err_corr   <= 1'b0;
            out_err_uncorr <= 1'b0;
        end else if (advance) begin
            out_valid      <= 1'b1;
            out_data       <= data_nx;
            out_syndrome   <= s1_syn;
            out_err_corr   <= corr_nx;
            out_err_uncorr <= uncorr_nx;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (clr_cnt) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (drain) begin
            if (out_err_corr && (corr_cnt != {CNT_W{1'b1}}))
                corr_cnt <= corr_cnt + CNT_W'(1);
            if (out_err_uncorr && (uncorr_cnt != {CNT_W{1'b1}}))
                uncorr_cnt <= uncorr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hamming_decoder.sv
// Bench for hamming_decoder: directed vectors, backpressure, reset, counter saturation, then
// random traffic checked against an index-XOR Hamming model and a word queue.
module tb_hamming_decoder;
    localparam int CW  = 2;
    localparam int SAT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [11:1]   in_code = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:1]    out_data;
    logic [3:0]    out_syndrome;
    logic          out_err_corr;
    logic          out_err_uncorr;
    logic          clr_cnt = 1'b0;
    logic [CW-1:0] corr_cnt;
    logic [CW-1:0] uncorr_cnt;

    hamming_decoder #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_syndrome(out_syndrome), .out_err_corr(out_err_corr),
        .out_err_uncorr(out_err_uncorr), .clr_cnt(clr_cnt),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Syndrome of a Hamming word is the XOR of the positions holding a 1.
    function automatic logic [3:0] syn_of(input logic [11:1] c);
        logic [3:0] s = '0;
        for (int i = 1; i <= 11; i++) if (c[i]) s ^= 4'(i);
        return s;
    endfunction

    function automatic logic [11:1] encode(input logic [7:1] d);
        int pos[7] = '{3, 5, 6, 7, 9, 10, 11};
        logic [11:1] c = '0;
        logic [3:0]  s;
        for (int k = 0; k < 7; k++) c[pos[k]] = d[k+1];
        s = syn_of(c);
        c[1] = s[0]; c[2] = s[1]; c[4] = s[2]; c[8] = s[3];
        return c;
    endfunction

    // {uncorr, corr, syndrome[3:0], data[7:1]}
    function automatic logic [12:0] expect_of(input logic [11:1] c);
        int pos[7] = '{3, 5, 6, 7, 9, 10, 11};
        logic [3:0]  s = syn_of(c);
        logic [11:1] f = c;
        logic [7:1]  d;
        int si = int'(s);
        if (si >= 1 && si <= 11) f[si] = ~f[si];
        for (int k = 0; k < 7; k++) d[k+1] = f[pos[k]];
        return {(si >= 12) ? 1'b1 : 1'b0, (si >= 1 && si <= 11) ? 1'b1 : 1'b0, s, d};
    endfunction

    function automatic logic [11:1] rand_code();
        logic [11:1] c = encode(7'($urandom));
        int n = $urandom_range(0, 4);
        if (n == 4) return 11'($urandom);
        for (int k = 0; k < n; k++) begin
            int p = $urandom_range(1, 11);
            c[p] = ~c[p];
        end
        return c;
    endfunction

    logic [11:1] q[$];
    int          mc = 0;
    int          mu = 0;
    logic        stall_prev = 1'b0;
    logic [12:0] snap;
    logic [12:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            mc = 0;
            mu = 0;
            stall_prev = 1'b0;
        end else begin
            chk("corr_cnt", corr_cnt, mc);
            chk("uncorr_cnt", uncorr_cnt, mu);
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_fields", {out_err_uncorr, out_err_corr, out_syndrome, out_data}, snap);
            end
            if (out_valid && out_ready) begin
                n_out++;
                chk("queue_nonempty", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = expect_of(q.pop_front());
                    chk("out_word", {out_err_uncorr, out_err_corr, out_syndrome, out_data}, e);
                    if (e[11] && mc < SAT) mc++;
                    if (e[12] && mu < SAT) mu++;
                end
            end
            if (clr_cnt) begin
                mc = 0;
                mu = 0;
            end
            stall_prev = out_valid & ~out_ready;
            snap = {out_err_uncorr, out_err_corr, out_syndrome, out_data};
            if (in_valid && in_ready) q.push_back(in_code);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:1] c);
        logic ok = 1'b0;
        in_valid = 1'b1;
        in_code  = c;
        for (int t = 0; t < 50; t++) begin
            if (!ok) begin
                @(negedge clk);
                if (in_ready) ok = 1'b1;
                tick();
            end
        end
        chk("send_accept", ok, 1);
        in_valid = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [11:1] c, input logic [7:1] d,
                            input logic [3:0] s, input logic fc, input logic fu);
        send(c);
        tick();
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_syn"}, out_syndrome, s);
        chk({tag, "_corr"}, out_err_corr, fc);
        chk({tag, "_uncorr"}, out_err_uncorr, fu);
        tick();
    endtask

    initial begin
        logic [11:1] w[5];
        logic [12:0] ew;
        int k;
        int base;

        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fields", {out_err_uncorr, out_err_corr, out_syndrome, out_data}, 0);
        chk("rst_cnts", {corr_cnt, uncorr_cnt}, 0);
        rst_n = 1'b1;
        tick();

        send(11'h54E);
        chk("clean_not_early", out_valid, 0);
        tick();
        chk("clean_valid", out_valid, 1);
        chk("clean_data", out_data, 7'h59);
        chk("clean_syn", out_syndrome, 0);
        chk("clean_flags", {out_err_corr, out_err_uncorr}, 0);
        tick();

        directed("single", 11'h56E, 7'h59, 4'd6, 1'b1, 1'b0);
        chk("single_cnt", corr_cnt, 1);
        directed("uncorr", 11'h5C6, 7'h59, 4'd12, 1'b0, 1'b1);
        chk("uncorr_cnt_dir", uncorr_cnt, 1);
        directed("alias", 11'h54D, 7'h58, 4'd3, 1'b1, 1'b0);

        // Backpressure: out_ready low for the first 4 cycles of a 5-word stream.
        for (int i = 0; i < 5; i++) w[i] = rand_code();
        ew = expect_of(w[0]);
        k = 0;
        base = n_out;
        for (int cyc = 0; cyc < 12; cyc++) begin
            out_ready = (cyc >= 4);
            in_valid  = (k < 5);
            if (k < 5) in_code = w[k];
            @(negedge clk);
            if (cyc == 2) chk("bp_in_ready_drop", in_ready, 0);
            if (cyc == 3) chk("bp_hold_data", out_data, ew[6:0]);
            if (in_valid && in_ready) k++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_accepted", k, 5);
        chk("bp_delivered", n_out - base, 5);

        // Reset in the middle of a stalled stream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = encode(7'h2A) ^ 11'h010;
        tick();
        in_code   = rand_code();
        tick();
        in_valid = 1'b0;
        #1;
        chk("mid_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_data", out_data, 0);
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        // Counter saturation at 3, then clear coinciding with a counted delivery.
        for (int i = 0; i < 5; i++) begin
            logic [11:1] c = encode(7'($urandom));
            int p = $urandom_range(1, 11);
            c[p] = ~c[p];
            send(c);
            tick();
            tick();
        end
        chk("cnt_saturate", corr_cnt, 3);
        send(encode(7'h11) ^ 11'h400);
        tick();
        chk("clr_pending_valid", out_valid, 1);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clr_wins", corr_cnt, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_code   = rand_code();
            out_ready = ($urandom_range(0, 3) != 0);
            clr_cnt   = ($urandom_range(0, 63) == 0);
            tick();
        end
        in_valid  = 1'b0;
        clr_cnt   = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        chk("queue_drained", q.size(), 0);
        chk("out_idle", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
